mc_responder: RTL and testbench
===============================

MC_RESPONDER -- requirements
Module: mc_responder

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 8; number of 64-bit word-index bits, giving 2^ADDR_WIDTH words of storage.
REQ-002 SHALL have parameter LATENCY, default 2; cycles from load acceptance to FIFO entry; legal values are 1 to 8.
REQ-003 SHALL have parameter FIFO_DEPTH, default 8; response FIFO entries; must be a power of two and at least 4.
REQ-004 SHALL have port clk, input, 1 bit; the single clock, all logic on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit; reset, asynchronous and active-low.
REQ-006 SHALL have port mc_req_ld, input, 1 bit; load request.
REQ-007 SHALL have port mc_req_st, input, 1 bit; store request.
REQ-008 SHALL have port mc_req_vadr, input, 48 bits; byte address.
REQ-009 SHALL have port mc_req_wrd_rdctl, input, 64 bits; store data on stores, rdctl tag in [31:0] on loads.
REQ-010 SHALL have port mc_req_stall, output, 1 bit; backpressure to the requester.
REQ-011 SHALL have port mc_rsp_rdctl, output, 32 bits; returned tag.
REQ-012 SHALL have port mc_rsp_data, output, 64 bits; returned data.
REQ-013 SHALL have port mc_rsp_push, output, 1 bit; response valid for exactly one cycle per response.
REQ-014 SHALL have port mc_rsp_stall, input, 1 bit; consumer backpressure.
REQ-015 SHALL have port err_overflow, output, 1 bit; sticky flag set when a response is dropped.

Function
REQ-016 Word index SHALL be mc_req_vadr[ADDR_WIDTH+2:3]; higher address bits ignored (aliasing wrap); bits [2:0] ignored.
REQ-017 Store SHALL write mc_req_wrd_rdctl to the addressed word at the rising edge where mc_req_st=1.
REQ-018 Load SHALL enter a LATENCY-stage valid/tag/data pipeline, capturing tag mc_req_wrd_rdctl[31:0].
REQ-019 Load and store in the same cycle SHALL both be performed; load returns pre-store contents, including same address.
REQ-020 Responses SHALL return in request order; no reordering.
REQ-021 FIFO head SHALL be driven onto mc_rsp_rdctl/mc_rsp_data with mc_rsp_push=1 and popped when FIFO non-empty and mc_rsp_stall=0; otherwise mc_rsp_push=0 and rdctl/data=0.
REQ-022 Minimum load-to-push latency SHALL be LATENCY+1 cycles (empty FIFO, mc_rsp_stall=0).
REQ-023 Outstanding count SHALL be FIFO occupancy plus valid pipeline stages; mc_req_stall SHALL be combinational (outstanding >= FIFO_DEPTH-2).
REQ-024 Requests arriving while mc_req_stall=1 SHALL still be accepted (2-entry skid).
REQ-025 Pipeline exit into a full FIFO SHALL drop that response and set err_overflow; simultaneous pop and push on a full FIFO SHALL NOT overflow.
REQ-026 FIFO pointers SHALL wrap modulo FIFO_DEPTH; occupancy counter width SHALL be log2(FIFO_DEPTH)+1.
REQ-027 mc_rsp_stall SHALL freeze only the FIFO pop; the pipeline continues to advance.

Reset
REQ-028 While rst=0: pipeline valids, FIFO pointers and occupancy, and err_overflow SHALL clear; mc_rsp_push, mc_rsp_rdctl and mc_rsp_data SHALL be 0.
REQ-029 Storage contents SHALL NOT be reset; reset mid-operation discards all in-flight and queued responses, and no push follows reset release without a new load.
REQ-030 mc_req_stall SHALL be 0 during and immediately after reset.

Configuration
REQ-031 With MC_STORE_ACK_EN defined, each store SHALL also enter the pipeline and return a response with rdctl = mc_req_wrd_rdctl[31:0] sampled at the store, data = 0, ordered with loads.
REQ-032 With MC_STORE_ACK_EN defined, a simultaneous load and store SHALL queue the load response first, then the store ack.
REQ-033 Without MC_STORE_ACK_EN, stores SHALL produce no response and not count toward outstanding.

Verification
REQ-034 Store 0x1122334455667788 at vadr 0x18, then load vadr 0x18 with tag 0x5 -> one push after LATENCY+1 cycles, rdctl 0x5, data 0x1122334455667788.
REQ-035 Same-cycle load and store at vadr 0x40 (old value 0xA, new value 0xB) -> load returns 0xA; a later load returns 0xB.
REQ-036 Hold mc_rsp_stall=1 and issue 8 back-to-back loads with tags 0 to 7 -> mc_req_stall rises once outstanding reaches 6; err_overflow stays 0 if loads stop at stall; release -> tags 0 to 7 pushed in order on consecutive cycles.
REQ-037 Continue issuing loads while stalled beyond the skid -> err_overflow=1 and stays 1 until reset; no push on a dropped tag.
REQ-038 ADDR_WIDTH=8: store at vadr 0x800 and load at vadr 0x0 -> same word returned (wrap).
REQ-039 Assert rst=0 with 3 loads in flight -> no push after release; memory retains prior store; with MC_STORE_ACK_EN a store yields rdctl echo and data 0.

Source files
------------

// File: rtl/mc_responder.sv
// Memory-controller responder: word storage, fixed-latency load pipeline and an in-order response FIFO.
// Define MC_STORE_ACK_EN to make every store return an acknowledgement response as well.
module mc_responder #(
    parameter int ADDR_WIDTH = 8,
    parameter int LATENCY    = 2,
    parameter int FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mc_req_ld,
    input  logic        mc_req_st,
    input  logic [47:0] mc_req_vadr,
    input  logic [63:0] mc_req_wrd_rdctl,
    output logic        mc_req_stall,
    output logic [31:0] mc_rsp_rdctl,
    output logic [63:0] mc_rsp_data,
    output logic        mc_rsp_push,
    input  logic        mc_rsp_stall,
    output logic        err_overflow
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int OW = $clog2(FIFO_DEPTH + 2 * LATENCY + 1) + 1;

    logic [63:0]           mem [2**ADDR_WIDTH];
    logic [ADDR_WIDTH-1:0] idx;
    logic                  unused_vadr;

    assign idx         = mc_req_vadr[ADDR_WIDTH+2:3];
    assign unused_vadr = ^{mc_req_vadr[47:ADDR_WIDTH+3], mc_req_vadr[2:0]};

    // Storage is deliberately never reset; the load path reads it before this edge's write.
    always_ff @(posedge clk) begin
        if (mc_req_st) begin
            mem[idx] <= mc_req_wrd_rdctl;
        end
    end

    logic ack_req;
`ifdef MC_STORE_ACK_EN
    assign ack_req = mc_req_st;
`else
    assign ack_req = 1'b0;
`endif

    // Each pipeline stage carries a load slot and a store-ack slot so a same-cycle pair stays ordered.
    logic [LATENCY-1:0] ld_v;
    logic [LATENCY-1:0] ack_v;
    logic [31:0]        ld_tag  [LATENCY];
    logic [63:0]        ld_data [LATENCY];
    logic [31:0]        ack_tag [LATENCY];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ld_v  <= '0;
            ack_v <= '0;
        end else begin
            ld_v[0]  <= mc_req_ld;
            ack_v[0] <= ack_req;
            for (int i = 1; i < LATENCY; i++) begin
                ld_v[i]  <= ld_v[i-1];
                ack_v[i] <= ack_v[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        ld_tag[0]  <= mc_req_wrd_rdctl[31:0];
        ld_data[0] <= mem[idx];
        ack_tag[0] <= mc_req_wrd_rdctl[31:0];
        for (int i = 1; i < LATENCY; i++) begin
            ld_tag[i]  <= ld_tag[i-1];
            ld_data[i] <= ld_data[i-1];
            ack_tag[i] <= ack_tag[i-1];
        end
    end

    logic [31:0]   fifo_tag  [FIFO_DEPTH];
    logic [63:0]   fifo_data [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] ack_ptr;
    logic [CW-1:0] count;
    logic [CW:0]   room;
    logic          pop;
    logic          acc_ld;
    logic          acc_ack;
    logic          drop;
    logic [OW-1:0] outstanding;

    // A pop in the same cycle frees one slot, so a full FIFO being drained does not overflow.
    always_comb begin
        pop     = (count != '0) && !mc_rsp_stall;
        room    = (CW+1)'(FIFO_DEPTH) - {1'b0, count} + (CW+1)'(pop);
        acc_ld  = ld_v[LATENCY-1] && (room != '0);
        acc_ack = ack_v[LATENCY-1] && (room > (CW+1)'(acc_ld));
        drop    = (ld_v[LATENCY-1] && !acc_ld) || (ack_v[LATENCY-1] && !acc_ack);
        ack_ptr = acc_ld ? wr_ptr + PW'(1) : wr_ptr;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            err_overflow <= 1'b0;
        end else begin
            wr_ptr       <= wr_ptr + PW'(acc_ld) + PW'(acc_ack);
            rd_ptr       <= rd_ptr + PW'(pop);
            count        <= count + CW'(acc_ld) + CW'(acc_ack) - CW'(pop);
            err_overflow <= err_overflow | drop;
        end
    end

    always_ff @(posedge clk) begin
        if (acc_ld) begin
            fifo_tag[wr_ptr]  <= ld_tag[LATENCY-1];
            fifo_data[wr_ptr] <= ld_data[LATENCY-1];
        end
        if (acc_ack) begin
            fifo_tag[ack_ptr]  <= ack_tag[LATENCY-1];
            fifo_data[ack_ptr] <= '0;
        end
    end

    always_comb begin
        outstanding = OW'(count);
        for (int i = 0; i < LATENCY; i++) begin
            outstanding = outstanding + OW'(ld_v[i]) + OW'(ack_v[i]);
        end
    end

    assign mc_req_stall = outstanding >= OW'(FIFO_DEPTH - 2);
    assign mc_rsp_push  = pop;
    assign mc_rsp_rdctl = pop ? fifo_tag[rd_ptr]  : '0;
    assign mc_rsp_data  = pop ? fifo_data[rd_ptr] : '0;

endmodule

// File: tb/tb_mc_responder.sv
// Scoreboard bench for mc_responder: directed requests queue expected responses, a negedge monitor checks pushes.
module tb_mc_responder;

    localparam int LAT   = 2;
    localparam int DEPTH = 8;
    localparam int AW    = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        mc_req_ld = 1'b0;
    logic        mc_req_st = 1'b0;
    logic [47:0] mc_req_vadr = '0;
    logic [63:0] mc_req_wrd_rdctl = '0;
    logic        mc_req_stall;
    logic [31:0] mc_rsp_rdctl;
    logic [63:0] mc_rsp_data;
    logic        mc_rsp_push;
    logic        mc_rsp_stall = 1'b0;
    logic        err_overflow;

    mc_responder #(.ADDR_WIDTH(AW), .LATENCY(LAT), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk),
        .rst(rst),
        .mc_req_ld(mc_req_ld),
        .mc_req_st(mc_req_st),
        .mc_req_vadr(mc_req_vadr),
        .mc_req_wrd_rdctl(mc_req_wrd_rdctl),
        .mc_req_stall(mc_req_stall),
        .mc_rsp_rdctl(mc_rsp_rdctl),
        .mc_rsp_data(mc_rsp_data),
        .mc_rsp_push(mc_rsp_push),
        .mc_rsp_stall(mc_rsp_stall),
        .err_overflow(err_overflow)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          checks = 0;
    int          errors = 0;
    int          push_count = 0;
    int          last_push_cyc = -1;
    logic [31:0] exp_tag_q [$];
    logic [63:0] exp_data_q [$];

    localparam logic [63:0] D18  = 64'h1122334455667788;
    localparam logic [63:0] D800 = 64'hDEADBEEFCAFEF00D;

    task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] required);
        checks++;
        if (actual !== required) begin
            errors++;
            $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, actual, required);
        end
    endtask

    // Monitor: every pushed response must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (mc_rsp_push === 1'b1) begin
            push_count++;
            last_push_cyc = cyc;
            if (exp_tag_q.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_push actual rdctl=0x%0h data=0x%0h required no push", mc_rsp_rdctl, mc_rsp_data);
            end else begin
                check_output("rsp_rdctl", {32'h0, mc_rsp_rdctl}, {32'h0, exp_tag_q.pop_front()});
                check_output("rsp_data", mc_rsp_data, exp_data_q.pop_front());
            end
        end else begin
            check_output("idle_push", {63'h0, mc_rsp_push}, 64'h0);
            check_output("idle_rdctl", {32'h0, mc_rsp_rdctl}, 64'h0);
            check_output("idle_data", mc_rsp_data, 64'h0);
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic apply_stimulus(input logic ld, input logic st, input logic [47:0] vadr,
                                  input logic [63:0] wrd, input logic [63:0] exp_data, input logic expect_rsp);
        if (ld && expect_rsp) begin
            exp_tag_q.push_back(wrd[31:0]);
            exp_data_q.push_back(exp_data);
        end
`ifdef MC_STORE_ACK_EN
        if (st && expect_rsp) begin
            exp_tag_q.push_back(wrd[31:0]);
            exp_data_q.push_back(64'h0);
        end
`endif
        mc_req_ld        = ld;
        mc_req_st        = st;
        mc_req_vadr      = vadr;
        mc_req_wrd_rdctl = wrd;
        @(posedge clk);
        #1;
        mc_req_ld = 1'b0;
        mc_req_st = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while (exp_tag_q.size() != 0 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (exp_tag_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL drain_timeout actual pending=%0d required 0", exp_tag_q.size());
        end
        idle(3);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout actual still running required finished");
        errors++;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "[TB] timeout");
    end

    initial begin
        int issue_cyc;
        int pc0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check_output("reset_push", {63'h0, mc_rsp_push}, 64'h0);
        check_output("reset_stall", {63'h0, mc_req_stall}, 64'h0);
        check_output("reset_err", {63'h0, err_overflow}, 64'h0);
        #2 rst = 1'b1;
        #1 check_output("stall_after_release", {63'h0, mc_req_stall}, 64'h0);
        @(posedge clk);
        #1;

        // Store then load with latency measurement
        apply_stimulus(1'b0, 1'b1, 48'h18, D18, 64'h0, 1'b1);
        issue_cyc = cyc;
        apply_stimulus(1'b1, 1'b0, 48'h18, 64'h5, D18, 1'b1);
        wait_drain();
        check_output("load_latency", 64'(last_push_cyc - issue_cyc), 64'(LAT + 1));

        // Same-cycle load and store return pre-store data
        apply_stimulus(1'b0, 1'b1, 48'h40, 64'hA, 64'h0, 1'b1);
        apply_stimulus(1'b1, 1'b1, 48'h40, 64'hB, 64'hA, 1'b1);
        apply_stimulus(1'b1, 1'b0, 48'h40, 64'h21, 64'hB, 1'b1);
        wait_drain();

        // Address aliasing and ignored low bits
        apply_stimulus(1'b0, 1'b1, 48'h800, D800, 64'h0, 1'b1);
        apply_stimulus(1'b1, 1'b0, 48'h0, 64'h38, D800, 1'b1);
        apply_stimulus(1'b1, 1'b0, 48'h7, 64'h39, D800, 1'b1);
        wait_drain();

        // Eight loads under consumer stall fill the skid exactly
        mc_rsp_stall = 1'b1;
        for (int k = 0; k < 8; k++) begin
            check_output("req_stall_level", {63'h0, mc_req_stall}, {63'h0, (k >= 6)});
            apply_stimulus(1'b1, 1'b0, 48'h18, 64'(k), D18, 1'b1);
        end
        idle(LAT + 2);
        check_output("stall_held_full", {63'h0, mc_req_stall}, 64'h1);
        check_output("no_overflow_at_skid", {63'h0, err_overflow}, 64'h0);
        check_output("queued_count", 64'(exp_tag_q.size()), 64'd8);
        mc_rsp_stall = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check_output("consecutive_push", {63'h0, mc_rsp_push}, 64'h1);
        end
        @(negedge clk);
        check_output("push_after_burst", {63'h0, mc_rsp_push}, 64'h0);
        @(posedge clk);
        #1;
        check_output("burst_drained", 64'(exp_tag_q.size()), 64'd0);

        // Ninth load beyond the skid is dropped and flagged
        mc_rsp_stall = 1'b1;
        for (int k = 0; k < 9; k++) begin
            apply_stimulus(1'b1, 1'b0, 48'h18, 64'(32'h100 + k), D18, (k < 8));
        end
        idle(LAT + 2);
        check_output("overflow_set", {63'h0, err_overflow}, 64'h1);
        pc0 = push_count;
        mc_rsp_stall = 1'b0;
        wait_drain();
        idle(2);
        check_output("overflow_push_count", 64'(push_count - pc0), 64'd8);
        check_output("overflow_sticky", {63'h0, err_overflow}, 64'h1);

        // Reset with loads in flight
        apply_stimulus(1'b0, 1'b1, 48'h20, 64'h55AA, 64'h0, 1'b1);
        wait_drain();
        for (int k = 0; k < 3; k++) begin
            apply_stimulus(1'b1, 1'b0, 48'h20, 64'(32'h200 + k), 64'h55AA, 1'b0);
        end
        #1 rst = 1'b0;
        #1;
        check_output("midreset_push", {63'h0, mc_rsp_push}, 64'h0);
        check_output("midreset_data", mc_rsp_data, 64'h0);
        check_output("midreset_err", {63'h0, err_overflow}, 64'h0);
        check_output("midreset_stall", {63'h0, mc_req_stall}, 64'h0);
        @(posedge clk);
        #3 rst = 1'b1;
        #1 check_output("stall_after_midreset", {63'h0, mc_req_stall}, 64'h0);
        pc0 = push_count;
        idle(10);
        check_output("no_push_after_reset", 64'(push_count - pc0), 64'd0);
        apply_stimulus(1'b1, 1'b0, 48'h20, 64'h300, 64'h55AA, 1'b1);
`ifdef MC_STORE_ACK_EN
        apply_stimulus(1'b0, 1'b1, 48'h28, 64'h777, 64'h0, 1'b1);
`endif
        wait_drain();
        check_output("final_err", {63'h0, err_overflow}, 64'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
